// File: rtl/pc_stack_unit.sv
// pc_stack_unit: fetch program counter with a return-address stack for jsb/ret.
// Overflow, underflow and push/pop collisions are latched as sticky error flags.
module pc_stack_unit #(
    parameter int ADDR_W = 12,
    parameter int DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic [1:0]               pc_src,
    input  logic                     stack_push,
    input  logic                     stack_pop,
    input  logic [ADDR_W-1:0]        target_addr,
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        ret_addr,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     proto_err
);
    localparam int AW = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d, inc, top;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [AW:0]       depth_q, depth_d;
    logic [AW-1:0]     top_idx;
    logic              ovf_q, ovf_d, unf_q, unf_d, perr_q, perr_d;
    logic              empty, full, push_only, pop_only, push_ok, pop_ok;

    assign empty     = depth_q == '0;
    assign full      = depth_q == (AW+1)'(DEPTH);
    assign inc       = pc_q + 1'b1;
    assign top_idx   = AW'(depth_q - 1'b1);
    assign top       = stack_q[top_idx];
    assign push_only = ~stall & stack_push & ~stack_pop;
    assign pop_only  = ~stall & stack_pop & ~stack_push;
    assign push_ok   = push_only & ~full;
    assign pop_ok    = pop_only & ~empty;

    always_comb begin
        pc_d    = stall            ? pc_q :
                  pc_src == 2'b00  ? inc :
                  pc_src == 2'b01  ? target_addr :
                  pc_src == 2'b10  ? (empty ? inc : top) : pc_q;
        depth_d = push_ok ? depth_q + 1'b1 : pop_ok ? depth_q - 1'b1 : depth_q;
        ovf_d   = ovf_q | (push_only & full);
        // a return from an empty stack is an underflow whether or not it pops
        unf_d   = unf_q | (~stall & empty & (pop_only | pc_src == 2'b10));
        perr_d  = perr_q | (~stall & stack_push & stack_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            stack_q[depth_q[AW-1:0]] <= inc;
    end

    assign pc          = pc_q;
    assign ret_addr    = empty ? '0 : top;
    assign depth       = depth_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign proto_err   = perr_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench; a queue-based stack model predicts every cycle's state.
module tb_pc_stack_unit;
    localparam int ADDR_W = 12;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic [1:0]        pc_src = 2'b00;
    logic              stack_push = 1'b0;
    logic              stack_pop = 1'b0;
    logic [ADDR_W-1:0] target_addr = '0;
    logic [ADDR_W-1:0] pc, ret_addr;
    logic [3:0]        depth;
    logic              stack_full, stack_empty, overflow, underflow, proto_err;

    pc_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src),
        .stack_push(stack_push), .stack_pop(stack_pop), .target_addr(target_addr),
        .pc(pc), .ret_addr(ret_addr), .depth(depth), .stack_full(stack_full),
        .stack_empty(stack_empty), .overflow(overflow), .underflow(underflow),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc, ret;
        int                depth;
        bit                full, empty, ov, uf, pe;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] m_stk[$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_ov, m_uf, m_pe;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = '0;
        m_stk.delete();
        m_ov = 0;
        m_uf = 0;
        m_pe = 0;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.ret   = m_stk.size() == 0 ? '0 : m_stk[m_stk.size()-1];
        e.depth = m_stk.size();
        e.full  = m_stk.size() == DEPTH;
        e.empty = m_stk.size() == 0;
        e.ov    = m_ov;
        e.uf    = m_uf;
        e.pe    = m_pe;
        return e;
    endfunction

    // drive one cycle's inputs mid-cycle, predict the post-edge state, return at edge+2
    task automatic step(input bit st, input bit [1:0] src, input bit pu, input bit po,
                        input logic [ADDR_W-1:0] tg);
        logic [ADDR_W-1:0] inc, npc;
        bit                was_empty;
        stall = st; pc_src = src; stack_push = pu; stack_pop = po; target_addr = tg;
        if (!st) begin
            inc = m_pc + 1;
            was_empty = m_stk.size() == 0;
            case (src)
                2'd0: npc = inc;
                2'd1: npc = tg;
                2'd2: npc = was_empty ? inc : m_stk[m_stk.size()-1];
                default: npc = m_pc;
            endcase
            if (src == 2'd2 && was_empty) m_uf = 1;
            if (pu && po) m_pe = 1;
            else if (pu) begin
                if (m_stk.size() == DEPTH) m_ov = 1;
                else m_stk.push_back(inc);
            end else if (po) begin
                if (was_empty) m_uf = 1;
                else void'(m_stk.pop_back());
            end
            m_pc = npc;
        end
        exp_q.push_back(snapshot());
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_depth"}, depth, 0);
        check({tag, "_empty"}, stack_empty, 1);
        check({tag, "_ret"}, ret_addr, 0);
        check({tag, "_flags"}, {overflow, underflow, proto_err}, 0);
    endtask

    // asynchronous reset asserted between edges; released mid-cycle
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 check_reset_state(tag);
        m_reset();
        stall = 0; stack_push = 0; stack_pop = 0; pc_src = 2'b00;
        #3 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("ret_addr", ret_addr, e.ret);
                check("depth", depth, e.depth);
                check("full", stack_full, e.full);
                check("empty", stack_empty, e.empty);
                check("overflow", overflow, e.ov);
                check("underflow", underflow, e.uf);
                check("proto_err", proto_err, e.pe);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [ADDR_W-1:0] tg;
        m_reset();
        #20 check_reset_state("reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 400; i++)
            step($urandom_range(7) == 0, 2'($urandom_range(3)), $urandom_range(3) == 0,
                 $urandom_range(3) == 0, ADDR_W'($urandom));
        async_reset("midrun_reset");
        for (int i = 0; i < 5; i++) step(0, 2'd0, 0, 0, '0);
        check("seq_pc5", pc, 5);
        step(0, 2'd1, 1, 0, 12'h040);
        check("call_pc", pc, 12'h040);
        check("call_ret", ret_addr, 6);
        step(0, 2'd2, 0, 1, '0);
        check("ret_pc", pc, 6);
        step(0, 2'd1, 1, 0, 12'h100);
        step(0, 2'd0, 0, 0, '0);
        step(0, 2'd1, 1, 0, 12'h200);
        step(0, 2'd2, 0, 1, '0);
        check("nested_ret1", pc, 12'h102);
        step(0, 2'd2, 0, 1, '0);
        check("nested_ret2", pc, 7);
        for (int i = 0; i < DEPTH; i++) step(0, 2'd1, 1, 0, ADDR_W'($urandom));
        step(0, 2'd1, 1, 0, 12'h007);
        check("ovf_pc", pc, 7);
        check("ovf_flag", overflow, 1);
        check("ovf_depth", depth, DEPTH);
        for (int i = 0; i < DEPTH; i++) step(0, 2'd2, 0, 1, '0);
        step(0, 2'd1, 0, 0, 12'h00A);
        step(0, 2'd2, 0, 1, '0);
        check("unf_pc", pc, 12'h00B);
        check("unf_flag", underflow, 1);
        step(0, 2'd0, 1, 1, '0);
        check("proto_flag", proto_err, 1);
        step(0, 2'd1, 0, 0, 12'hFFF);
        step(0, 2'd0, 0, 0, '0);
        check("wrap_pc", pc, 0);
        step(0, 2'd1, 1, 0, 12'h300);
        tg = pc;
        step(1, 2'd1, 1, 0, 12'h055);
        check("stall_pc", pc, tg);
        check("stall_depth", depth, 1);
        step(0, 2'd2, 1, 1, '0);
        check("peek_pc", pc, 12'h001);
        for (int i = 0; i < 200; i++)
            step($urandom_range(7) == 0, 2'($urandom_range(3)), $urandom_range(2) == 0,
                 $urandom_range(3) == 0, ADDR_W'($urandom));
        async_reset("final_reset");
        check("drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter and return-address-stack unit for the 19-bit single-cycle core.
- Consumes the controller's next-PC select (pc_src) and stack_push/stack_pop strobes, plus a precomputed jump/branch target from the datapath.
- Produces the fetch address every cycle.
- Maintains a hardware call stack for jsb/ret.
- Reports stack overflow, underflow and protocol errors as sticky flags.

Parameters:
ADDR_W, 12, width of PC, target and stack entries
DEPTH, 8, number of return-address stack entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  1 = hold PC and stack; stack_push/stack_pop ignored
pc_src  input  2  00 = pc+1, 01 = target_addr, 10 = return (stack top), 11 = hold
stack_push  input  1  push return address pc+1 (jsb)
stack_pop  input  1  pop stack top (ret)
target_addr  input  ADDR_W  jump/branch destination from datapath
pc  output  ADDR_W  current fetch address
ret_addr  output  ADDR_W  current stack top; 0 when empty
depth  output  $clog2(DEPTH)+1  number of valid entries
stack_full  output  1  depth == DEPTH
stack_empty  output  1  depth == 0
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
proto_err  output  1  sticky: push and pop in same cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, depth = 0.
  - overflow, underflow and proto_err = 0.
  - Stack storage contents don't-care; ret_addr reads 0 while empty.
  - Reset has effect immediately, mid-operation included.
  - Release is sampled at the next rising edge.
- All state updates on the rising clk edge. Inputs are sampled at that edge, so there is one cycle of latency from pc_src to the new pc.
- stall = 1: pc, stack and depth hold. Flags hold; no error detection while stalled.
- Next PC (stall = 0), with inc = pc + 1 modulo 2^ADDR_W (wrap at all ones to 0):
  - 00 → inc
  - 01 → target_addr
  - 10 → stack top if not empty; else inc and underflow set
  - 11 → pc unchanged
- Push (stack_push = 1, stack_pop = 0):
  - Not full: entry[depth] = inc, depth += 1.
  - Full: no write, depth unchanged, overflow set; the PC update still follows pc_src.
- Pop (stack_pop = 1, stack_push = 0):
  - Not empty: depth -= 1, and the top entry is the value used for pc_src = 10.
  - Empty: depth stays 0, underflow set.
  - Pop with pc_src != 10 still discards the top (no PC effect beyond pc_src).
- pc_src = 10 without stack_pop:
  - PC loads the top, stack unchanged (peek).
  - Empty stack: falls back to inc and sets underflow.
- Push and pop both 1: both stack operations are ignored, proto_err is set, and pc follows pc_src. For pc_src = 10 this uses the top without popping.
- Sticky flags clear only on reset.
- ret_addr, stack_full and stack_empty are combinational from the registered stack state.
- Nested calls: LIFO order. Push stores inc of the calling PC, so the return resumes at the instruction after jsb.

Test Plan:
1. Reset then 3 cycles of pc_src = 00 → pc = 0,1,2,3; depth = 0, stack_empty = 1, all flags 0.
2. At pc = 5: pc_src = 01, push, target = 0x040. Next: pc = 0x040, ret_addr = 6, depth = 1. Then pc_src = 10 with pop → pc = 6, depth = 0.
3. Nested calls: jsb at pc = 2 → 0x100; jsb at 0x101 → 0x200; two rets → pc = 0x102 then 3, i.e. LIFO order.
4. Push 8 times (DEPTH = 8), then a 9th push with target = 0x7 → stack_full = 1, depth = 8, overflow = 1, pc = 0x7. Eight pops then return the original addresses in reverse order.
5. Empty stack, pc_src = 10 with pop at pc = 0x0A → pc = 0x0B, underflow = 1, depth = 0. A push and pop in the same cycle → proto_err = 1, depth unchanged.
6. pc = 0xFFF with pc_src = 00 → pc = 0x000. With stall = 1 and a push requested, pc and depth hold. Asserting rst_n low between clock edges → pc = 0 and depth = 0 immediately.
